// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR frame sequencer.
package fir_pkg;

    localparam int unsigned DATA_WIDTH   = 8;
    localparam int unsigned SIZE_WIDTH   = 12;
    localparam int unsigned TAP_NUMS     = 3;
    localparam int unsigned MIN_SIZE     = TAP_NUMS;
    localparam int unsigned FLUSH_LINES  = (TAP_NUMS - 1) / 2;
    localparam int unsigned DRAIN_CYCLES = 8;
    localparam int unsigned DRAIN_WIDTH  = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_FLUSH,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // One pixel beat as presented to the FIR
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  first_ln;
        logic                  last_ln;
        logic                  flush;
        logic [SIZE_WIDTH-1:0] x;
        logic [SIZE_WIDTH-1:0] y;
    } fir_beat_t;

endpackage

// File: rtl/fir_frame_seq_if.sv
// Pixel input stream and FIR output stream of the frame sequencer.
interface fir_frame_seq_if;

    logic                          in_valid_i;
    logic                          in_ready_o;
    logic [fir_pkg::DATA_WIDTH-1:0] in_data_i;
    logic                          fir_ready_i;
    logic                          fir_ce_o;
    logic [fir_pkg::DATA_WIDTH-1:0] fir_data_o;
    logic                          fir_first_ln_o;
    logic                          fir_last_ln_o;
    logic                          fir_flush_o;
    logic [fir_pkg::SIZE_WIDTH-1:0] x_o;
    logic [fir_pkg::SIZE_WIDTH-1:0] y_o;

    // Sequencer side
    modport master (
        input  in_valid_i, in_data_i, fir_ready_i,
        output in_ready_o, fir_ce_o, fir_data_o, fir_first_ln_o,
               fir_last_ln_o, fir_flush_o, x_o, y_o
    );

    // Source / FIR side
    modport slave (
        output in_valid_i, in_data_i, fir_ready_i,
        input  in_ready_o, fir_ce_o, fir_data_o, fir_first_ln_o,
               fir_last_ln_o, fir_flush_o, x_o, y_o
    );

endinterface

// File: rtl/fir_xy_cnt.sv
// Raster x/y counter: position of the next pixel to issue, plus line/frame flags.
module fir_xy_cnt
    import fir_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  en,
    input  logic [SIZE_WIDTH-1:0] h_size,
    input  logic [SIZE_WIDTH-1:0] v_size,
    output logic [SIZE_WIDTH-1:0] x,
    output logic [SIZE_WIDTH-1:0] y,
    output logic                  first_ln,
    output logic                  last_ln,
    output logic                  last_pix,
    output logic                  last_flush
);

    logic x_wrap;

    assign x_wrap     = (x == h_size - SIZE_WIDTH'(1));
    assign first_ln   = (y == '0);
    assign last_ln    = (y == v_size - SIZE_WIDTH'(1));
    assign last_pix   = x_wrap && last_ln;
    // Flush rows continue past the frame, so the last one sits at v_size+FLUSH_LINES-1
    assign last_flush = x_wrap && (y == v_size + SIZE_WIDTH'(FLUSH_LINES) - SIZE_WIDTH'(1));

    // Advance x, wrapping into the next row
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (en) begin
            if (x_wrap) begin
                x <= '0;
                y <= y + SIZE_WIDTH'(1);
            end else begin
                x <= x + SIZE_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/fir_frame_seq.sv
// Frame sequencer: feeds one pixel per enabled cycle to the 3-tap 2D FIR,
// pads the frame with flush lines, drains the pipeline and signals done.
module fir_frame_seq
    import fir_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [SIZE_WIDTH-1:0] h_size_i,
    input  logic [SIZE_WIDTH-1:0] v_size_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  cfg_err_o,
    fir_frame_seq_if.master       bus
);

    state_t                 state, state_next;
    logic [SIZE_WIDTH-1:0]  h_size, v_size;
    logic [DRAIN_WIDTH-1:0] drain_cnt;
    logic [SIZE_WIDTH-1:0]  cnt_x, cnt_y;
    logic                   cnt_first_ln, cnt_last_ln, cnt_last_pix, cnt_last_flush;
    logic                   cfg_ok, accept, reject, cnt_en, xfer;
    logic                   ce_q, ce_d;
    fir_beat_t              beat_q, beat_d;

    assign bus.in_ready_o = (state == ST_ACTIVE) && bus.fir_ready_i;
    assign xfer           = bus.in_valid_i && bus.in_ready_o;
    assign cfg_ok         = (h_size_i >= SIZE_WIDTH'(MIN_SIZE)) && (v_size_i >= SIZE_WIDTH'(MIN_SIZE));

    fir_xy_cnt u_xy_cnt (
        .clk        (clk),
        .rst        (rst),
        .clear      (accept),
        .en         (cnt_en),
        .h_size     (h_size),
        .v_size     (v_size),
        .x          (cnt_x),
        .y          (cnt_y),
        .first_ln   (cnt_first_ln),
        .last_ln    (cnt_last_ln),
        .last_pix   (cnt_last_pix),
        .last_flush (cnt_last_flush)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next state and the beat to register for the FIR
    always_comb begin
        state_next      = state;
        accept          = 1'b0;
        reject          = 1'b0;
        cnt_en          = 1'b0;
        ce_d            = 1'b0;
        beat_d          = beat_q;
        beat_d.first_ln = 1'b0;
        beat_d.last_ln  = 1'b0;
        beat_d.flush    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    if (cfg_ok) begin
                        accept     = 1'b1;
                        state_next = ST_ACTIVE;
                    end else begin
                        reject     = 1'b1;
                    end
                end
            end
            ST_ACTIVE: begin
                if (xfer) begin
                    cnt_en = 1'b1;
                    ce_d   = 1'b1;
                    beat_d = '{data: bus.in_data_i, first_ln: cnt_first_ln, last_ln: cnt_last_ln,
                               flush: 1'b0, x: cnt_x, y: cnt_y};
                    if (cnt_last_pix) state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (bus.fir_ready_i) begin
                    cnt_en = 1'b1;
                    ce_d   = 1'b1;
                    beat_d = '{data: '0, first_ln: 1'b0, last_ln: 1'b0,
                               flush: 1'b1, x: cnt_x, y: cnt_y};
                    if (cnt_last_flush) state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == DRAIN_WIDTH'(DRAIN_CYCLES - 1)) state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Frame sizes latched on an accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_size <= '0;
            v_size <= '0;
        end else if (accept) begin
            h_size <= h_size_i;
            v_size <= v_size_i;
        end
    end

    // Pipeline drain counter, idle outside DRAIN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    drain_cnt <= '0;
        else if (state == ST_DRAIN) drain_cnt <= drain_cnt + DRAIN_WIDTH'(1);
        else                        drain_cnt <= '0;
    end

    // Registered status and FIR outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            cfg_err_o <= 1'b0;
            ce_q      <= 1'b0;
            beat_q    <= '0;
        end else begin
            busy_o    <= (state != ST_IDLE);
            done_o    <= (state == ST_DONE);
            cfg_err_o <= reject;
            ce_q      <= ce_d;
            beat_q    <= beat_d;
        end
    end

    assign bus.fir_ce_o       = ce_q;
    assign bus.fir_data_o     = beat_q.data;
    assign bus.fir_first_ln_o = beat_q.first_ln;
    assign bus.fir_last_ln_o  = beat_q.last_ln;
    assign bus.fir_flush_o    = beat_q.flush;
    assign bus.x_o            = beat_q.x;
    assign bus.y_o            = beat_q.y;

endmodule
